logic_op_arbiter: RTL and testbench

//  Shares one AND/OR logic unit (result = op ? (a|b) : (a&b), bitwise) between two

---
 rtl/logic_op_arbiter.sv | 108 ++++++++++
 tb/tb_logic_op_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin arbiter sharing one AND/OR unit between two requesters
// One operation in flight: accept in IDLE, compute in EXEC, hold result in RESP until taken.
module logic_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic             id_q;

  // A sole requester wins outright; under contention the one not served last wins.
  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands are captured at accept so later requester changes cannot disturb the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      if (state == IDLE && accept) begin
        a_q        <= grant ? req1_a : req0_a;
        b_q        <= grant ? req1_b : req0_b;
        op_q       <= grant ? req1_op : req0_op;
        id_q       <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= op_q ? (a_q | b_q) : (a_q & b_q);
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - randomized self-checking bench for logic_op_arbiter
// A second instance with a 2-bit counter runs on the same stimulus to exercise count wrap.
module tb_logic_op_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_op = 1'b0, req1_op = 1'b0;
  logic       rsp_ready = 1'b0;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [7:0]  rsp_data;
  logic [15:0] op_count;
  logic        req0_ready_w, req1_ready_w, rsp_valid_w, rsp_id_w, busy_w;
  logic [7:0]  rsp_data_w;
  logic [1:0]  op_count_w;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic_op_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  logic_op_arbiter #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_w), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready_w), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready), .rsp_data(rsp_data_w), .rsp_id(rsp_id_w),
    .busy(busy_w), .op_count(op_count_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one op pending; its result appears one cycle after acceptance.
  logic       m_pend = 1'b0;
  int         m_age = 0;
  logic [7:0] m_res = '0, m_out_data = '0;
  logic       m_id = 1'b0, m_out_id = 1'b0, m_last = 1'b1;
  int         m_count = 0;
  logic       hs0 = 1'b0, hs1 = 1'b0;

  initial begin
    logic er0, er1, win, ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 1'b0; m_age = 0; m_out_data = '0; m_out_id = 1'b0;
        m_last = 1'b1; m_count = 0; hs0 = 1'b0; hs1 = 1'b0;
      end else begin
        win = (req0_valid && req1_valid) ? !m_last : req1_valid;
        er0 = !m_pend && req0_valid && !win;
        er1 = !m_pend && req1_valid && win;
        ev  = m_pend && (m_age >= 1);
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_data", rsp_data, m_out_data);
        chk("rsp_id", rsp_id, m_out_id);
        chk("busy", busy, m_pend);
        chk("op_count", op_count, m_count & 32'hFFFF);
        chk("w_req0_ready", req0_ready_w, er0);
        chk("w_req1_ready", req1_ready_w, er1);
        chk("w_rsp_valid", rsp_valid_w, ev);
        chk("w_rsp_data", rsp_data_w, m_out_data);
        chk("w_rsp_id", rsp_id_w, m_out_id);
        chk("w_busy", busy_w, m_pend);
        chk("w_op_count", op_count_w, m_count & 3);
        hs0 = er0;
        hs1 = er1;
        if (m_pend) begin
          if (m_age == 0) begin
            m_age = 1; m_out_data = m_res; m_out_id = m_id;
          end else if (rsp_ready) begin
            m_pend = 1'b0; m_count++;
          end
        end else if (er0 || er1) begin
          m_pend = 1'b1; m_age = 0; m_id = er1; m_last = er1;
          if (er1) m_res = req1_op ? (req1_a | req1_b) : (req1_a & req1_b);
          else     m_res = req0_op ? (req0_a | req0_b) : (req0_a & req0_b);
        end
      end
    end
  end

  initial begin
    bit found;
    #8;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    #4 rst_n = 1'b1;

    // single AND from requester 0
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 0; rsp_ready = 1;
    @(negedge clk); chk("t2_ready0", req0_ready, 1);
    @(posedge clk); #1; req0_valid = 0; req0_a = 8'h00;
    @(negedge clk); chk("t2_exec_valid", rsp_valid, 0); chk("t2_exec_busy", busy, 1);
    @(negedge clk); chk("t2_valid", rsp_valid, 1); chk("t2_data", rsp_data, 8'h30); chk("t2_id", rsp_id, 0);
    @(negedge clk); chk("t2_done_busy", busy, 0); chk("t2_count", op_count, 1); chk("t2_wcount", op_count_w, 1);

    // single OR from requester 1
    @(posedge clk); #1;
    req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h0F; req1_op = 1;
    @(negedge clk); chk("t3_ready1", req1_ready, 1); chk("t3_ready0", req0_ready, 0);
    @(posedge clk); #1; req1_valid = 0;
    @(negedge clk);
    @(negedge clk); chk("t3_data", rsp_data, 8'hFF); chk("t3_id", rsp_id, 1);
    @(negedge clk); chk("t3_count", op_count, 2); chk("t3_wcount", op_count_w, 2);

    // contention: strict alternation starting at requester 0
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 8'hA5; req0_b = 8'h5A; req0_op = 1;
    req1_valid = 1; req1_a = 8'hCC; req1_b = 8'h0F; req1_op = 0;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int t = 0; t < 10 && !found; t++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) found = 1;
      end
      chk("t4_found", found, 1);
      chk("t4_grant", req1_ready, k % 2);
      chk("t4_excl", req0_ready & req1_ready, 0);
      @(posedge clk); #1;
      if (k == 3) begin req0_valid = 0; req1_valid = 0; end
    end
    repeat (3) @(negedge clk);
    chk("t4_count", op_count, 6); chk("t4_wcount_wrapped", op_count_w, 2);

    // backpressure
    @(posedge clk); #1;
    rsp_ready = 0; req0_valid = 1; req0_a = 8'hAA; req0_b = 8'h0F; req0_op = 1;
    @(negedge clk); chk("t5_ready0", req0_ready, 1);
    @(posedge clk); #1; req0_valid = 0; req1_valid = 1; req1_a = 8'h55; req1_b = 8'h11; req1_op = 0;
    @(negedge clk); chk("t5_exec_ready1", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", rsp_valid, 1); chk("t5_hold_data", rsp_data, 8'hAF);
      chk("t5_hold_rdy", {req0_ready, req1_ready}, 0); chk("t5_hold_busy", busy, 1);
    end
    @(posedge clk); #1; rsp_ready = 1; req1_valid = 0;
    @(negedge clk); chk("t5_last_valid", rsp_valid, 1);
    @(negedge clk); chk("t5_idle_busy", busy, 0); chk("t5_idle_valid", rsp_valid, 0);
    chk("t5_count", op_count, 7); chk("t5_wcount", op_count_w, 3);

    // randomized traffic checked by the model
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom);
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end

    // asynchronous reset while a response is waiting
    @(posedge clk); #1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) @(posedge clk);
    #1; rsp_ready = 0; req0_valid = 1; req0_a = 8'h0F; req0_b = 8'hFF; req0_op = 0;
    @(negedge clk); chk("t1_ready0", req0_ready, 1);
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk);
    @(negedge clk); chk("t1_pre_valid", rsp_valid, 1); chk("t1_pre_data", rsp_data, 8'h0F);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", rsp_valid, 0); chk("t1_busy", busy, 0); chk("t1_count", op_count, 0);
    chk("t1_data", rsp_data, 0); chk("t1_wcount", op_count_w, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_after_valid", rsp_valid, 0); chk("t1_after_count", op_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
